// File: rtl/ptp_ts_capture.sv
// ptp_ts_capture: latches PTP time on RX/TX start-of-frame pulses, adds per-channel latency,
// and queues {chan, tag, time} records in a first-word-fall-through FIFO with a registered output.
module ptp_ts_capture #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] RX_LAT_NS  = 16'd0,
    parameter logic [15:0] TX_LAT_NS  = 16'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [63:0]                   time_ptp_ns,
    input  logic                          rx_sof,
    input  logic [15:0]                   rx_tag,
    input  logic                          tx_sof,
    input  logic [15:0]                   tx_tag,
    output logic                          ts_valid,
    input  logic                          ts_ready,
    output logic [63:0]                   ts_time,
    output logic [15:0]                   ts_tag,
    output logic                          ts_chan,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = 81;

    logic          hold_rx_v, hold_tx_v;
    logic [RW-1:0] hold_rx, hold_tx, wr_data, mem_q;
    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, full, wr_en, drain_rx, drain_tx, drop_rx, drop_tx;
    logic          mem_empty, load, mem_wr;
    logic [16:0]   drop_sum;

    assign pop       = ts_valid & ts_ready;
    assign full      = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign wr_en     = (hold_rx_v | hold_tx_v) & (~full | pop);
    assign drain_rx  = wr_en & hold_rx_v;
    assign drain_tx  = wr_en & ~hold_rx_v;
    assign wr_data   = hold_rx_v ? hold_rx : hold_tx;
    assign drop_rx   = rx_sof & hold_rx_v & ~drain_rx;
    assign drop_tx   = tx_sof & hold_tx_v & ~drain_tx;
    assign mem_empty = wr_ptr == rd_ptr;
    assign load      = ~ts_valid | pop;
    // An empty memory with a free output stage lets the write bypass straight to the output
    assign mem_wr    = wr_en & ~(load & mem_empty);
    assign drop_sum  = {1'b0, drop_cnt} + 17'(drop_rx) + 17'(drop_tx);
    assign mem_q     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_rx_v  <= 1'b0;
            hold_tx_v  <= 1'b0;
            hold_rx    <= '0;
            hold_tx    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ts_valid   <= 1'b0;
            ts_time    <= '0;
            ts_tag     <= '0;
            ts_chan    <= 1'b0;
            drop_cnt   <= '0;
            fifo_level <= '0;
        end else begin
            hold_rx_v <= rx_sof | (hold_rx_v & ~drain_rx);
            hold_tx_v <= tx_sof | (hold_tx_v & ~drain_tx);
            if (rx_sof & ~drop_rx)
                hold_rx <= {1'b0, rx_tag, time_ptp_ns + {48'd0, RX_LAT_NS}};
            if (tx_sof & ~drop_tx)
                hold_tx <= {1'b1, tx_tag, time_ptp_ns + {48'd0, TX_LAT_NS}};
            if (mem_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                ts_valid <= ~mem_empty | wr_en;
                if (!mem_empty) begin
                    {ts_chan, ts_tag, ts_time} <= mem_q;
                    rd_ptr <= rd_ptr + 1'b1;
                end else if (wr_en) begin
                    {ts_chan, ts_tag, ts_time} <= wr_data;
                end
            end
            fifo_level <= fifo_level + (AW+1)'(wr_en) - (AW+1)'(pop);
            drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule
